if_fetch: RTL
=============

// Module: if_fetch
// PURPOSE
//  Instruction fetch unit: producer of the {inst, inst_addr} stream consumed by the decode stage via if_id.
//  Drives PC, issues word reads to instruction memory over a req/gnt/rvalid bus, buffers responses,
//  presents them in order with valid/ready. Executes redirects (jump/branch) from EX, discarding in-flight fetches.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH  2              response buffer entries (power of 2, >=2); also max in-flight+buffered fetches
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   asynchronous, active-high reset
//  mem_req_o      out  1   fetch request valid
//  mem_addr_o     out  32  fetch address, word aligned
//  mem_gnt_i      in   1   request accepted this cycle (req&gnt = issue)
//  mem_rvalid_i   in   1   read data valid; responses in issue order, >=1 cycle after gnt
//  mem_rdata_i    in   32  instruction word
//  inst_o         out  32  instruction to if_id; `INST_NOP when inst_valid_o=0
//  inst_addr_o    out  32  PC of inst_o; 0 when inst_valid_o=0
//  inst_valid_o   out  1   inst_o/inst_addr_o valid
//  inst_ready_i   in   1   consumer accepts (valid&ready = pop)
//  jump_en_i      in   1   redirect request from EX
//  jump_addr_i    in   32  redirect target
//  fetch_err_o    out  1   misaligned redirect flag (IF_MISALIGN_CHK_EN only, else tied 0)
// BEHAVIOUR
//  Reset: mem_req_o=0, mem_addr_o=RESET_PC, inst_valid_o=0, inst_o=`INST_NOP, inst_addr_o=0,
//   fetch_err_o=0, fifo empty, outstanding=0, drop_cnt=0, state=S_IDLE.
//  FSM S_IDLE -> S_FETCH unconditionally next cycle (req stays low in S_IDLE).
//   S_FETCH: mem_req_o=1 iff outstanding+fifo_count < FIFO_DEPTH (guarantees every response has a slot).
//    On issue: fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0), outstanding++.
//   jump_en_i in S_FETCH: fifo cleared, fetch_pc <= {jump_addr_i[31:2],2'b00}, drop_cnt <= outstanding
//    (+1 if issue same cycle), -> S_DRAIN if that value >0, else stay S_FETCH.
//   S_DRAIN: mem_req_o=0; each rvalid decrements drop_cnt and data is discarded; drop_cnt==1 with rvalid
//    -> S_FETCH next cycle. jump_en_i in S_DRAIN: only fetch_pc updated, drop_cnt unchanged.
//  rvalid in S_FETCH: push {fetch addr, rdata} to fifo, outstanding--; push+pop same cycle allowed.
//  Output: inst_valid_o = !fifo_empty (combinational from fifo head); latency gnt->valid = rvalid cycle +1.
//  Head held stable while valid & !ready. Pop on valid&ready.
//  Priority: jump_en_i > pop > push; a pop in the jump cycle is discarded (EX flushes if_id that cycle).
//  Response address: per-entry PC queue tracks issued addresses (depth FIFO_DEPTH, same pointers scheme).
//  rst mid-operation: all state cleared immediately; stale responses after rst deasserts are a bus
//   protocol violation (memory must also reset).
// CONFIGURATION
//  IF_MISALIGN_CHK_EN defined: jump_en_i with jump_addr_i[1:0]!=0 sets fetch_err_o=1 (sticky until rst),
//   redirect still taken with low bits cleared. Undefined: no check, fetch_err_o tied 0, bits silently cleared.
// STRUCTURE
//  defines.v: `INST_NOP (32'h0000_0013), state encodings S_IDLE/S_FETCH/S_DRAIN, `ZERO_WORD.
//  Sub-module if_fifo: sync FIFO, params WIDTH=64/DEPTH, ports clk,rst,push,pop,clr,din,dout,count,empty,full;
//   clr dominates push/pop. One instance for {pc,inst}; PC tracking queue may be a second instance (WIDTH=32).
// TESTING
//  1 Reset, gnt=1, rvalid 1 cycle after gnt, ready=1 -> addrs 0,4,8,... issued; inst_addr_o follows, one per cycle.
//  2 ready=0 for 5 cycles -> at most 2 issued, req drops, inst_o/inst_addr_o stable at addr 0; release resumes in order.
//  3 Jump to 32'h100 with 2 outstanding, rvalid 3 cycles late -> both responses dropped, first valid inst_addr_o=32'h100.
//  4 Jump asserted in same cycle as req&gnt and rvalid -> 2 drops counted, no stale inst emitted, next fetch 32'h100.
//  5 Random gnt/rvalid/ready stalls 10k cycles vs reference PC model -> no loss, no duplicate, in-order, never overflow.
//  6 IF_MISALIGN_CHK_EN: jump to 32'h102 -> fetch_err_o=1 sticky, fetch resumes at 32'h100; undefined: err stays 0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants, FSM state encoding and small helpers for the
// instruction fetch unit and its buffers.
package if_fetch_pkg;

    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    // One buffered response: the PC it was fetched from and the instruction word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: small synchronous FIFO used for the response buffer and the
// issued-PC tracking queue. A clear wins over push and pop in the same cycle.
module if_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are only meaningful while count says so, hence no reset.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch unit. Issues word reads over a req/gnt/rvalid bus,
// buffers responses with their PCs and hands them to decode with valid/ready.
// Redirects from EX flush the buffer and discard responses still in flight.
// Optional build macro IF_MISALIGN_CHK_EN: flags misaligned redirect targets on
// fetch_err_o (sticky until reset); without it fetch_err_o is tied low.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        fetch_err_o
);

    localparam int             CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_pc_next;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] drop_cnt_next;
    logic [CNT_W-1:0] pending;

    // The PC queue holds one entry per request still awaiting its response,
    // so its count is the outstanding-request counter.
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W:0]   occupancy;
    logic             buf_empty;
    logic             buf_full;
    logic             pcq_empty;
    logic             pcq_full;
    logic [31:0]      pcq_dout;
    logic [63:0]      buf_dout;
    fetch_entry_t     head;

    logic issue;
    logic resp_accept;
    logic buf_pop;
    logic flush;

    // Only request when every in-flight response is guaranteed a buffer slot.
    assign occupancy   = {1'b0, outstanding} + {1'b0, buf_count};
    assign mem_req_o   = (state == S_FETCH) && (occupancy < DEPTH_EXT) && !pcq_full && !buf_full;
    assign mem_addr_o  = fetch_pc;
    assign issue       = mem_req_o && mem_gnt_i;
    assign flush       = jump_en_i;
    assign resp_accept = (state == S_FETCH) && mem_rvalid_i && !pcq_empty;
    assign buf_pop     = inst_valid_o && inst_ready_i;

    assign head         = fetch_entry_t'(buf_dout);
    assign inst_valid_o = !buf_empty;
    assign inst_o       = inst_valid_o ? head.inst : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? head.pc   : ZERO_WORD;

    if_fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .pop   (resp_accept),
        .clr   (flush),
        .din   (mem_addr_o),
        .dout  (pcq_dout),
        .count (outstanding),
        .empty (pcq_empty),
        .full  (pcq_full)
    );

    if_fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_resp_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_accept),
        .pop   (buf_pop),
        .clr   (flush),
        .din   ({pcq_dout, mem_rdata_i}),
        .dout  (buf_dout),
        .count (buf_count),
        .empty (buf_empty),
        .full  (buf_full)
    );

    // Next-state logic: advance the PC on issue, redirect on jump, and drain
    // responses that belong to the abandoned path before fetching again.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        drop_cnt_next = drop_cnt;
        // Requests still unanswered after this cycle; a response arriving in the
        // jump cycle is already consumed (and thrown away), so it is not waited for.
        pending       = outstanding + CNT_W'(issue) - CNT_W'(resp_accept);
        unique case (state)
            S_IDLE: begin
                state_next = S_FETCH;
                if (jump_en_i) fetch_pc_next = word_align(jump_addr_i);
            end
            S_FETCH: begin
                if (issue) fetch_pc_next = fetch_pc + 32'd4;
                if (jump_en_i) begin
                    fetch_pc_next = word_align(jump_addr_i);
                    drop_cnt_next = pending;
                    if (pending != '0) state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_rvalid_i) begin
                    drop_cnt_next = drop_cnt - 1'b1;
                    if (drop_cnt == CNT_W'(1)) state_next = S_FETCH;
                end
                if (jump_en_i) fetch_pc_next = word_align(jump_addr_i);
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, fetch PC and drop counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            drop_cnt <= drop_cnt_next;
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    // Sticky flag for any redirect whose target is not word aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_err_o <= 1'b0;
        end else if (jump_en_i && is_misaligned(jump_addr_i)) begin
            fetch_err_o <= 1'b1;
        end
    end
`else
    assign fetch_err_o = 1'b0;
`endif

endmodule
